dds_phase_ctrl: RTL and testbench
=================================

// Module: dds_phase_ctrl
// PURPOSE
//  Read-side driver for the DDS sine ROM (sin_rom, registered q, 1-cycle read latency).
//  - Runs a phase accumulator and issues one ROM address per clock.
//  - Realigns the returned ROM samples with a valid flag and a wrap marker.
//  - Offers a valid/ready config port for frequency and phase words.
//  Sits between the DDS control registers and the DAC/output stage.
// PARAMETERS
//  PHASE_WIDTH  32  accumulator and frequency word width
//  ADDR_WIDTH   12  ROM address width; must be <= PHASE_WIDTH
//  DATA_WIDTH   12  ROM data width
//  ROM_LAT      1   ROM addr->q latency in clocks; must be >= 1
//  OUT_SIGNED   0   1: invert dout MSB (offset-binary -> two's complement)
// PORTS
//  clk         in   1            system clock, all logic on rising edge
//  rst         in   1            synchronous, active-high reset
//  en          in   1            run request; level-sensitive
//  cfg_valid   in   1            config word present
//  cfg_ready   out  1            config accepted when cfg_valid & cfg_ready
//  freq_word   in   PHASE_WIDTH  phase increment per clock
//  phase_word  in   ADDR_WIDTH   phase offset added to the address
//  rom_addr    out  ADDR_WIDTH   address to sin_rom
//  rom_q       in   DATA_WIDTH   sin_rom data, valid ROM_LAT clocks after rom_addr
//  dout        out  DATA_WIDTH   registered sine sample
//  dout_valid  out  1            dout holds a real sample
//  wrap        out  1            1-clk marker on the first sample after accumulator carry-out
//  busy        out  1            state != IDLE
// BEHAVIOUR
//  Reset (on any edge with rst=1, including mid-run):
//   - outputs rom_addr, dout, dout_valid, wrap, busy all = 0; cfg_ready = 1.
//   - internal: acc = 0, freq_r = 0, phase_r = 0, pipelines cleared, state = IDLE.
//  Config:
//   - cfg_ready = 1 in IDLE and RUN, 0 in DRAIN.
//   - On handshake, freq_r/phase_r load at that edge.
//   - Acceptance on the same edge as IDLE->RUN: the new words apply to the first address.
//  FSM IDLE / RUN / DRAIN:
//   - IDLE, en=1  -> RUN. Same edge: acc <= 0; rom_addr <= phase; addr_vld <= 1.
//   - RUN,  en=1  -> each edge: acc_n = acc + freq (mod 2^PHASE_WIDTH);
//                    rom_addr <= acc_n[PHASE_WIDTH-1 -: ADDR_WIDTH] + phase (mod 2^ADDR_WIDTH);
//                    carry <= carry-out of the add.
//   - RUN,  en=0  -> DRAIN. Same edge: addr_vld <= 0; acc and rom_addr hold.
//   - DRAIN       -> counts ROM_LAT+1 edges, then IDLE. en is ignored in DRAIN.
//  Output pipeline:
//   - addr_vld and carry are delayed through a ROM_LAT shift register.
//   - Final edge: dout <= rom_q (MSB inverted when OUT_SIGNED); dout_valid and wrap <= delayed flags.
//   - Latency: rom_addr edge -> dout edge = ROM_LAT+1 clocks. First dout_valid comes ROM_LAT+1
//     edges after the IDLE->RUN edge.
//   - dout holds its last value when dout_valid = 0.
//  Boundaries:
//   - freq_word = 0: constant address, continuous valid samples.
//   - Accumulator and address additions wrap silently; no saturation.
//   - Reset during RUN or DRAIN discards all in-flight samples; no valid output on the next edge.
// STRUCTURE
//  - Shared package dds_pkg: localparams S_IDLE=2'd0, S_RUN=2'd1, S_DRAIN=2'd2;
//    default widths (PHASE/ADDR/DATA).
//  - Sub-module dds_vld_pipe: parameterised delay line (depth ROM_LAT, width 2) carrying addr_vld and carry.
//  - The ROM is external; sin_rom is instantiated only in the bench.
// TESTING (bench instantiates sin_rom with ADDR 12 / DATA 12, clk period 20 ns)
//  1. freq=2^20, phase=0, en=1 -> rom_addr = 0,1,2,... per clock; dout(t) = ROM[rom_addr(t-2)];
//     dout_valid first high 2 clocks after start.
//  2. freq=2^31 -> rom_addr alternates 0,2048; wrap pulses with every sample from addr 0
//     after the first carry.
//  3. phase=1024 at start, freq=2^20 -> first rom_addr = 1024; addr 4095 followed by 0.
//  4. Mid-run cfg freq 2^20->2^21 -> rom_addr step changes from 1 to 2 on the edge after the handshake.
//  5. en drop -> cfg_ready=0; dout_valid stays high 2 more clocks then low; busy low after 2 edges.
//     en re-raised in DRAIN is ignored until IDLE.
//  6. rst=1 mid-run -> next edge: dout_valid=0, rom_addr=0, busy=0; restart reproduces scenario 1 exactly.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS read-side driver: FSM state encoding and default widths.
package dds_pkg;

    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } dds_state_e;

endpackage

// File: rtl/dds_vld_pipe.sv
// Fixed-depth delay line that keeps the sample flags aligned with the ROM read latency.
module dds_vld_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dds_phase_ctrl.sv
// Phase accumulator that addresses the external sine ROM once per clock and
// realigns the returned samples with valid and wrap flags.
module dds_phase_ctrl
    import dds_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ROM_LAT     = 1,
    parameter int OUT_SIGNED  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [ADDR_WIDTH-1:0]  phase_word,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   wrap,
    output logic                   busy
);

    localparam int CNT_W = $clog2(ROM_LAT + 1) + 1;

    dds_state_e             state_q, state_d;
    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] freq_q, freq_d;
    logic [ADDR_WIDTH-1:0]  phase_q, phase_d;
    logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                   addr_vld_q, addr_vld_d;
    logic                   carry_q, carry_d;
    logic [CNT_W-1:0]       drain_cnt_q, drain_cnt_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   wrap_q, wrap_d;

    logic [PHASE_WIDTH:0]   acc_sum;
    logic [DATA_WIDTH-1:0]  sample;
    logic [1:0]             pipe_out;
    logic                   cfg_hs;

    dds_vld_pipe #(
        .DEPTH (ROM_LAT),
        .WIDTH (2)
    ) u_vld_pipe (
        .clk    (clk),
        .rst    (rst),
        .din_i  ({carry_q, addr_vld_q}),
        .dout_o (pipe_out)
    );

    assign cfg_ready = (state_q != S_DRAIN);
    assign cfg_hs    = cfg_valid & cfg_ready;
    assign acc_sum   = {1'b0, acc_q} + {1'b0, freq_q};

    always_comb begin
        sample = rom_q;
        if (OUT_SIGNED != 0) begin
            sample[DATA_WIDTH-1] = ~rom_q[DATA_WIDTH-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        freq_d       = freq_q;
        phase_d      = phase_q;
        rom_addr_d   = rom_addr_q;
        addr_vld_d   = 1'b0;
        carry_d      = 1'b0;
        drain_cnt_d  = drain_cnt_q;
        dout_d       = pipe_out[0] ? sample : dout_q;
        dout_valid_d = pipe_out[0];
        wrap_d       = pipe_out[0] & pipe_out[1];

        if (cfg_hs) begin
            freq_d  = freq_word;
            phase_d = phase_word;
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                    acc_d   = '0;
                    // A word accepted on the start edge must steer the very first address.
                    rom_addr_d = cfg_hs ? phase_word : phase_q;
                    addr_vld_d = 1'b1;
                end
            end
            S_RUN: begin
                if (en) begin
                    acc_d      = acc_sum[PHASE_WIDTH-1:0];
                    rom_addr_d = acc_sum[PHASE_WIDTH-1 -: ADDR_WIDTH] + phase_q;
                    carry_d    = acc_sum[PHASE_WIDTH];
                    addr_vld_d = 1'b1;
                end else begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                // Stay long enough for the last issued address to reach dout.
                if (drain_cnt_q == CNT_W'(ROM_LAT)) begin
                    state_d     = S_IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            freq_q       <= '0;
            phase_q      <= '0;
            rom_addr_q   <= '0;
            addr_vld_q   <= 1'b0;
            carry_q      <= 1'b0;
            drain_cnt_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            freq_q       <= freq_d;
            phase_q      <= phase_d;
            rom_addr_q   <= rom_addr_d;
            addr_vld_q   <= addr_vld_d;
            carry_q      <= carry_d;
            drain_cnt_q  <= drain_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign wrap       = wrap_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Directed bench for dds_phase_ctrl with a behavioural 1-cycle-latency ROM stand-in.
module tb_dds_phase_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] freq_word;
    logic [11:0] phase_word;
    logic [11:0] rom_addr;
    logic [11:0] rom_q;
    logic [11:0] dout;
    logic        dout_valid;
    logic        wrap;
    logic        busy;

    int errors = 0;
    int checks = 0;

    dds_phase_ctrl #(
        .PHASE_WIDTH (32),
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (12),
        .ROM_LAT     (1),
        .OUT_SIGNED  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .freq_word  (freq_word),
        .phase_word (phase_word),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .dout       (dout),
        .dout_valid (dout_valid),
        .wrap       (wrap),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Bijective contents so every address yields a distinguishable word.
    function automatic logic [11:0] rom_fn(input logic [11:0] a);
        return (a * 12'd37) ^ 12'h5A3;
    endfunction

    always @(posedge clk) rom_q <= rom_fn(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        freq_word  = '0;
        phase_word = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        checks++; if (dout !== 12'd0) begin errors++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    // freq 2^20, phase 0 from IDLE: address k on edge k, dout two edges behind.
    task automatic run_sweep(input string name, input int n);
        freq_word  = 32'h0010_0000;
        phase_word = 12'd0;
        cfg_valid  = 1'b1;
        en         = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            cfg_valid = 1'b0;
            checks++; if (rom_addr !== 12'(k)) begin errors++; $display("FAIL %s_addr k=%0d got=%0d exp=%0d", name, k, rom_addr, k); end
            checks++; if (dout_valid !== (k >= 2)) begin errors++; $display("FAIL %s_valid k=%0d got=%b exp=%b", name, k, dout_valid, (k >= 2)); end
            checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL %s_wrap k=%0d got=%b exp=0", name, k, wrap); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy k=%0d got=%b exp=1", name, k, busy); end
            if (k >= 2) begin
                checks++; if (dout !== rom_fn(12'(k - 2))) begin errors++; $display("FAIL %s_dout k=%0d got=%0d exp=%0d", name, k, dout, rom_fn(12'(k - 2))); end
            end
        end
    endtask

    task automatic test_sweep();
        apply_reset();
        run_sweep("sweep", 12);
        $display("test_sweep done: errors=%0d", errors);
    endtask

    task automatic test_half_rate_wrap();
        logic [11:0] exp_addr;
        logic        exp_wrap;
        apply_reset();
        freq_word  = 32'h8000_0000;
        phase_word = 12'd0;
        cfg_valid  = 1'b1;
        en         = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            cfg_valid = 1'b0;
            exp_addr = (k % 2 == 1) ? 12'd2048 : 12'd0;
            // Sample issued at edge k-2 carried out when it is an even edge past the start.
            exp_wrap = (k >= 4) && (k % 2 == 0);
            checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL half_addr k=%0d got=%0d exp=%0d", k, rom_addr, exp_addr); end
            checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL half_wrap k=%0d got=%b exp=%b", k, wrap, exp_wrap); end
            if (k >= 2) begin
                checks++; if (dout !== rom_fn(12'(((k - 2) % 2) * 2048))) begin errors++; $display("FAIL half_dout k=%0d got=%0d", k, dout); end
            end
        end
        $display("test_half_rate_wrap done: errors=%0d", errors);
    endtask

    task automatic test_phase_offset();
        logic [11:0] exp_addr;
        apply_reset();
        freq_word  = 32'h0010_0000;
        phase_word = 12'd1024;
        cfg_valid  = 1'b1;
        en         = 1'b1;
        for (int k = 0; k < 3076; k++) begin
            tick();
            cfg_valid = 1'b0;
            exp_addr = 12'(1024 + k);
            checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL phase_addr k=%0d got=%0d exp=%0d", k, rom_addr, exp_addr); end
            // Address wraps at 4095->0 here, but the accumulator has not carried.
            checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL phase_wrap k=%0d got=%b exp=0", k, wrap); end
            if (k >= 2) begin
                checks++; if (dout !== rom_fn(12'(1024 + k - 2))) begin errors++; $display("FAIL phase_dout k=%0d got=%0d exp=%0d", k, dout, rom_fn(12'(1024 + k - 2))); end
            end
        end
        $display("test_phase_offset done: errors=%0d", errors);
    endtask

    task automatic test_cfg_midrun();
        apply_reset();
        freq_word  = 32'h0010_0000;
        phase_word = 12'd0;
        cfg_valid  = 1'b1;
        en         = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (5) tick();
        checks++; if (rom_addr !== 12'd5) begin errors++; $display("FAIL cfg_pre_addr got=%0d exp=5", rom_addr); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_run_ready got=%b exp=1", cfg_ready); end
        freq_word = 32'h0020_0000;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checks++; if (rom_addr !== 12'd6) begin errors++; $display("FAIL cfg_hs_addr got=%0d exp=6", rom_addr); end
        tick();
        checks++; if (rom_addr !== 12'd8) begin errors++; $display("FAIL cfg_step1_addr got=%0d exp=8", rom_addr); end
        tick();
        checks++; if (rom_addr !== 12'd10) begin errors++; $display("FAIL cfg_step2_addr got=%0d exp=10", rom_addr); end
        $display("test_cfg_midrun done: errors=%0d", errors);
    endtask

    task automatic test_drain();
        apply_reset();
        freq_word  = 32'h0010_0000;
        phase_word = 12'd0;
        cfg_valid  = 1'b1;
        en         = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (5) tick();
        en = 1'b0;
        tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL drain0_ready got=%b exp=0", cfg_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain0_busy got=%b exp=1", busy); end
        checks++; if (rom_addr !== 12'd5) begin errors++; $display("FAIL drain0_addr got=%0d exp=5", rom_addr); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL drain0_valid got=%b exp=1", dout_valid); end
        checks++; if (dout !== rom_fn(12'd4)) begin errors++; $display("FAIL drain0_dout got=%0d exp=%0d", dout, rom_fn(12'd4)); end
        en = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL drain1_ready got=%b exp=0", cfg_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain1_busy got=%b exp=1", busy); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL drain1_valid got=%b exp=1", dout_valid); end
        checks++; if (dout !== rom_fn(12'd5)) begin errors++; $display("FAIL drain1_dout got=%0d exp=%0d", dout, rom_fn(12'd5)); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain2_busy got=%b exp=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL drain2_ready got=%b exp=1", cfg_ready); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL drain2_valid got=%b exp=0", dout_valid); end
        checks++; if (dout !== rom_fn(12'd5)) begin errors++; $display("FAIL drain2_hold got=%0d exp=%0d", dout, rom_fn(12'd5)); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
        checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL restart_addr got=%0d exp=0", rom_addr); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL restart_valid got=%b exp=0", dout_valid); end
        tick();
        checks++; if (rom_addr !== 12'd1) begin errors++; $display("FAIL restart1_addr got=%0d exp=1", rom_addr); end
        tick();
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL restart2_valid got=%b exp=1", dout_valid); end
        checks++; if (dout !== rom_fn(12'd0)) begin errors++; $display("FAIL restart2_dout got=%0d exp=%0d", dout, rom_fn(12'd0)); end
        en = 1'b0;
        $display("test_drain done: errors=%0d", errors);
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        freq_word  = 32'h0010_0000;
        phase_word = 12'd0;
        cfg_valid  = 1'b1;
        en         = 1'b1;
        tick();
        cfg_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", dout_valid); end
        checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL rstmid_addr got=%0d exp=0", rom_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (dout !== 12'd0) begin errors++; $display("FAIL rstmid_dout got=%0d exp=0", dout); end
        rst = 1'b0;
        run_sweep("rerun", 12);
        $display("test_reset_midrun done: errors=%0d", errors);
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        freq_word  = '0;
        phase_word = '0;
        test_reset();
        test_sweep();
        test_half_rate_wrap();
        test_phase_offset();
        test_cfg_midrun();
        test_drain();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
